// File: rtl/sic1_mem_arbiter_if.sv
// One requester's view of the shared SIC-1 memory: request, accept, and read return.
interface sic1_mem_arbiter_if;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       gnt;
    logic       rvalid;
    logic [7:0] rdata;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sic1_mem_arbiter.sv
// Shares the single-port 256x8 SIC-1 memory between core and debug host, with a host lock.
// One access per cycle, registered memory command, read data returned 2 cycles after accept.
module sic1_mem_arbiter #(
    parameter bit PRIORITY = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    sic1_mem_arbiter_if.slave        cpu,
    sic1_mem_arbiter_if.slave        dbg,
    input  logic                     dbg_lock,
    output logic                     dbg_locked,
    output logic [7:0]               mem_addr,
    output logic                     mem_wr_en,
    output logic [7:0]               mem_data_in,
    input  logic [7:0]               mem_data_out
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    lock_state_t state;
    lock_state_t state_nxt;

    logic       last_dbg;
    logic       cpu_elig;
    logic       cpu_go;
    logic       dbg_go;
    logic       xfer;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;

    logic       s1_rd;
    logic       s1_tag;
    logic       core_busy;

    logic       cpu_rvalid_q;
    logic       dbg_rvalid_q;
    logic [7:0] cpu_rdata_q;
    logic [7:0] dbg_rdata_q;

    // The core is masked the same cycle dbg_lock rises, and stays out until RUN again.
    always_comb begin
        cpu_elig = cpu.req && (state == RUN) && !dbg_lock;
        if (cpu_elig && dbg.req) begin
            dbg_go = PRIORITY ? 1'b1 : !last_dbg;
        end else begin
            dbg_go = dbg.req;
        end
        cpu_go    = cpu_elig && !dbg_go;
        xfer      = cpu_go || dbg_go;
        sel_we    = dbg_go ? dbg.we    : cpu.we;
        sel_addr  = dbg_go ? dbg.addr  : cpu.addr;
        sel_wdata = dbg_go ? dbg.wdata : cpu.wdata;
    end

    assign cpu.gnt = cpu_go;
    assign dbg.gnt = dbg_go;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr    <= 8'h00;
            mem_wr_en   <= 1'b0;
            mem_data_in <= 8'h00;
            s1_rd       <= 1'b0;
            s1_tag      <= 1'b0;
            last_dbg    <= 1'b0;
        end else begin
            mem_wr_en <= xfer && sel_we;
            s1_rd     <= xfer && !sel_we;
            s1_tag    <= dbg_go;
            if (xfer) begin
                mem_addr    <= sel_addr;
                mem_data_in <= sel_wdata;
                last_dbg    <= dbg_go;
            end
        end
    end

    // Memory read data is combinational from mem_addr, so it is captured while stage 1 still holds the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 8'h00;
            dbg_rdata_q  <= 8'h00;
        end else begin
            cpu_rvalid_q <= s1_rd && !s1_tag;
            dbg_rvalid_q <= s1_rd && s1_tag;
            if (s1_rd && !s1_tag) begin
                cpu_rdata_q <= mem_data_out;
            end
            if (s1_rd && s1_tag) begin
                dbg_rdata_q <= mem_data_out;
            end
        end
    end

    assign cpu.rvalid = cpu_rvalid_q;
    assign cpu.rdata  = cpu_rdata_q;
    assign dbg.rvalid = dbg_rvalid_q;
    assign dbg.rdata  = dbg_rdata_q;

    // Core traffic still in flight: a command in stage 1 or a read return in stage 2.
    assign core_busy = ((s1_rd || mem_wr_en) && !s1_tag) || cpu_rvalid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (dbg_lock) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!dbg_lock)      state_nxt = RUN;
                else if (!core_busy) state_nxt = LOCKED;
            end
            LOCKED: begin
                if (!dbg_lock) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        dbg_locked = 1'b0;
        if (state == LOCKED) dbg_locked = 1'b1;
    end

endmodule

// File: tb/tb_sic1_mem_arbiter.sv
// Scoreboard bench: reference memory and grant/lock rules checked against two arbiter instances.
module tb_sic1_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sic1_mem_arbiter_if cpu_if ();
    sic1_mem_arbiter_if dbg_if ();
    sic1_mem_arbiter_if cpu1_if ();
    sic1_mem_arbiter_if dbg1_if ();

    logic       dbg_lock;
    logic       dbg_locked;
    logic       dbg_locked1;
    logic [7:0] mem_addr, mem_data_in, mem_data_out;
    logic       mem_wr_en;
    logic [7:0] mem_addr1, mem_data_in1, mem_rd1;
    logic       mem_wr_en1;

    logic [7:0] mem [256];
    assign mem_data_out = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_data_in;

    // The priority instance sees the same requests; only its grants are checked.
    assign cpu1_if.req   = cpu_if.req;
    assign cpu1_if.we    = cpu_if.we;
    assign cpu1_if.addr  = cpu_if.addr;
    assign cpu1_if.wdata = cpu_if.wdata;
    assign dbg1_if.req   = dbg_if.req;
    assign dbg1_if.we    = dbg_if.we;
    assign dbg1_if.addr  = dbg_if.addr;
    assign dbg1_if.wdata = dbg_if.wdata;
    assign mem_rd1       = 8'h00;

    sic1_mem_arbiter #(.PRIORITY(1'b0)) dut (
        .clk(clk), .rst(rst), .cpu(cpu_if.slave), .dbg(dbg_if.slave),
        .dbg_lock(dbg_lock), .dbg_locked(dbg_locked),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    sic1_mem_arbiter #(.PRIORITY(1'b1)) dut_pri (
        .clk(clk), .rst(rst), .cpu(cpu1_if.slave), .dbg(dbg1_if.slave),
        .dbg_lock(dbg_lock), .dbg_locked(dbg_locked1),
        .mem_addr(mem_addr1), .mem_wr_en(mem_wr_en1), .mem_data_in(mem_data_in1),
        .mem_data_out(mem_rd1)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic [7:0] ref_mem [256];
    exp_t exp_cpu[$];
    exp_t exp_dbg[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   m_last_dbg, prev_lock, cpu_taken, dbg_taken;
    int   lock_start, xw, xr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_last_dbg = 1'b0;
        prev_lock  = 1'b0;
        cpu_taken  = 1'b0;
        dbg_taken  = 1'b0;
        lock_start = -100;
        xw         = -100;
        xr         = -100;
        exp_cpu.delete();
        exp_dbg.delete();
    endtask

    task automatic set_idle();
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = 8'h00; cpu_if.wdata = 8'h00;
        dbg_if.req = 1'b0; dbg_if.we = 1'b0; dbg_if.addr = 8'h00; dbg_if.wdata = 8'h00;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cpu_gnt"},    32'(cpu_if.gnt),    0);
        chk({tag, "_dbg_gnt"},    32'(dbg_if.gnt),    0);
        chk({tag, "_cpu_rvalid"}, 32'(cpu_if.rvalid), 0);
        chk({tag, "_dbg_rvalid"}, 32'(dbg_if.rvalid), 0);
        chk({tag, "_cpu_rdata"},  32'(cpu_if.rdata),  0);
        chk({tag, "_dbg_rdata"},  32'(dbg_if.rdata),  0);
        chk({tag, "_mem_addr"},   32'(mem_addr),      0);
        chk({tag, "_mem_wr_en"},  32'(mem_wr_en),     0);
        chk({tag, "_mem_data"},   32'(mem_data_in),   0);
        chk({tag, "_locked"},     32'(dbg_locked),    0);
        chk({tag, "_p1_locked"},  32'(dbg_locked1),   0);
    endtask

    // Called just after the negedge with inputs for this cycle already driven.
    task automatic step();
        logic ce, pd, cg, dg, exp_lk;
        int   n;
        exp_t e;
        #1;
        n  = cyc;
        ce = cpu_if.req && !dbg_lock && !prev_lock;
        pd = (ce && dbg_if.req) ? !m_last_dbg : dbg_if.req;
        cg = ce && !pd;
        dg = pd;
        chk("cpu_gnt",    32'(cpu_if.gnt),  32'(cg));
        chk("dbg_gnt",    32'(dbg_if.gnt),  32'(dg));
        chk("p1_cpu_gnt", 32'(cpu1_if.gnt), 32'(ce && !dbg_if.req));
        chk("p1_dbg_gnt", 32'(dbg1_if.gnt), 32'(dbg_if.req));
        if (dbg_lock && !prev_lock) lock_start = n;
        exp_lk = prev_lock && (n >= lock_start + 2) && (n >= xw + 3) && (n >= xr + 4);
        chk("dbg_locked", 32'(dbg_locked), 32'(exp_lk));
        if (cg) begin
            if (cpu_if.we) begin
                ref_mem[cpu_if.addr] = cpu_if.wdata;
                xw = n;
            end else begin
                e.data = ref_mem[cpu_if.addr];
                e.due  = n + 2;
                exp_cpu.push_back(e);
                xr = n;
            end
            m_last_dbg = 1'b0;
        end
        if (dg) begin
            if (dbg_if.we) begin
                ref_mem[dbg_if.addr] = dbg_if.wdata;
            end else begin
                e.data = ref_mem[dbg_if.addr];
                e.due  = n + 2;
                exp_dbg.push_back(e);
            end
            m_last_dbg = 1'b1;
        end
        cpu_taken = cg;
        dbg_taken = dg;
        prev_lock = dbg_lock;
        @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (cpu_if.rvalid) begin
                if (exp_cpu.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
                else begin
                    e = exp_cpu.pop_front();
                    chk("cpu_rdata", 32'(cpu_if.rdata), 32'(e.data));
                    chk("cpu_rvalid_cycle", cyc, e.due);
                end
            end else if (exp_cpu.size() > 0 && exp_cpu[0].due <= cyc) begin
                chk("cpu_rvalid_missing", 0, 1);
                e = exp_cpu.pop_front();
            end
            if (dbg_if.rvalid) begin
                if (exp_dbg.size() == 0) chk("dbg_rvalid_unexpected", 1, 0);
                else begin
                    e = exp_dbg.pop_front();
                    chk("dbg_rdata", 32'(dbg_if.rdata), 32'(e.data));
                    chk("dbg_rvalid_cycle", cyc, e.due);
                end
            end else if (exp_dbg.size() > 0 && exp_dbg[0].due <= cyc) begin
                chk("dbg_rvalid_missing", 0, 1);
                e = exp_dbg.pop_front();
            end
        end
    end

    initial begin
        rst      = 1'b1;
        dbg_lock = 1'b0;
        set_idle();
        model_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        step();

        // Sustained contention: round-robin starts with dbg after reset.
        for (int k = 0; k < 6; k++) begin
            cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 8'h20;
            dbg_if.req = 1'b1; dbg_if.we = 1'b0; dbg_if.addr = 8'h21;
            #1;
            chk("rr_dbg_gnt", 32'(dbg_if.gnt), 32'(k % 2 == 0));
            chk("pri_dbg_gnt", 32'(dbg1_if.gnt), 1);
            step();
        end
        set_idle();
        repeat (3) step();

        dbg_if.req = 1'b1; dbg_if.we = 1'b1; dbg_if.addr = 8'h10; dbg_if.wdata = 8'h5A;
        step();
        dbg_if.we = 1'b0;
        step();
        set_idle();
        repeat (3) step();
        chk("dbg_rdata_5a", 32'(dbg_if.rdata), 32'h5A);

        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 8'h30; cpu_if.wdata = 8'h07;
        step();
        cpu_if.we = 1'b0;
        step();
        set_idle();
        repeat (3) step();
        chk("cpu_rdata_07", 32'(cpu_if.rdata), 32'h07);

        // Lock raised the cycle after a core read accept; host traffic continues.
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 8'h20;
        step();
        cpu_if.addr = 8'h21;
        dbg_lock = 1'b1;
        for (int k = 0; k < 6; k++) begin
            dbg_if.req = 1'b1; dbg_if.we = (k % 2 == 0); dbg_if.addr = 8'h40; dbg_if.wdata = 8'(k + 1);
            #1 chk("lock_cpu_masked", 32'(cpu_if.gnt), 0);
            step();
        end
        chk("locked_in_time", 32'(dbg_locked), 1);
        dbg_lock = 1'b0;
        dbg_if.req = 1'b0;
        step();
        step();
        set_idle();
        repeat (3) step();

        for (int i = 0; i < 400; i++) begin
            if (!cpu_if.req || cpu_taken) begin
                cpu_if.req   = ($urandom_range(0, 3) != 0);
                cpu_if.we    = 1'($urandom_range(0, 1));
                cpu_if.addr  = 8'($urandom_range(0, 15));
                cpu_if.wdata = 8'($urandom);
            end
            if (!dbg_if.req || dbg_taken) begin
                dbg_if.req   = 1'($urandom_range(0, 1));
                dbg_if.we    = 1'($urandom_range(0, 1));
                dbg_if.addr  = 8'($urandom_range(0, 15));
                dbg_if.wdata = 8'($urandom);
            end
            if ($urandom_range(0, 19) == 0) dbg_lock = !dbg_lock;
            step();
        end
        dbg_lock = 1'b0;
        set_idle();
        repeat (5) step();

        // Reset the cycle after a host read accept: the read must never return.
        dbg_if.req = 1'b1; dbg_if.we = 1'b0; dbg_if.addr = 8'h10;
        step();
        set_idle();
        #2 rst = 1'b1;
        model_reset();
        #1 check_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) step();

        chk("cpu_queue_empty", exp_cpu.size(), 0);
        chk("dbg_queue_empty", exp_dbg.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
